// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single register-file write port. It arbitrates
// between pipeline writeback (A, fixed priority) and long-latency writeback
// (B, starvation-protected), registers the winner onto rd_we/rd_num/rd_data,
// and tracks registers whose long-latency results are still outstanding.
//
// Handshake: a port transfers on a cycle where valid & ready are both high at
// the rising edge. Ready never depends on the same port's valid. Both readies
// are low while rst_b is low.
module rf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        a_valid,
   input  logic [4:0]  a_num,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_num,
   input  logic [31:0] b_data,
   output logic        b_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_num,
   input  logic [4:0]  rs_num,
   input  logic [4:0]  rt_num,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic        rd_we,
   output logic [4:0]  rd_num,
   output logic [31:0] rd_data,
   output logic        sb_err
);

   localparam logic [2:0] LP_LIMIT = 3'(STARVE_LIMIT);

   logic [2:0]  r_starve_cnt;
   logic        r_rd_we;
   logic [4:0]  r_rd_num;
   logic [31:0] r_rd_data;
   logic [31:0] r_pending;
   logic        r_sb_err;

   logic        w_starve_hit;
   logic        w_a_ready;
   logic        w_b_ready;
   logic        w_a_xfer;
   logic        w_b_xfer;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;
   logic [31:0] w_pending_nxt;
   logic        w_dup_issue;

   // B has waited long enough to pre-empt A.
   assign w_starve_hit = (r_starve_cnt >= LP_LIMIT);

   // A is held off only when B is starving; B goes when A is idle or starving.
   assign w_a_ready = rst_b & ~(b_valid & w_starve_hit);
   assign w_b_ready = rst_b & (~a_valid | w_starve_hit);
   assign w_a_xfer  = a_valid & w_a_ready;
   assign w_b_xfer  = b_valid & w_b_ready;

   assign a_ready = w_a_ready;
   assign b_ready = w_b_ready;

   // Count consecutive cycles B is held off; saturate at 7, clear otherwise.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_starve_cnt <= 3'd0;
      end else if (b_valid && !w_b_ready) begin
         if (r_starve_cnt != 3'd7) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
         end
      end else begin
         r_starve_cnt <= 3'd0;
      end
   end

   // Register the winning write; r0 writes complete the handshake but never assert rd_we.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_rd_we   <= 1'b0;
         r_rd_num  <= 5'd0;
         r_rd_data <= 32'd0;
      end else if (w_a_xfer) begin
         r_rd_we   <= (a_num != 5'd0);
         r_rd_num  <= a_num;
         r_rd_data <= a_data;
      end else if (w_b_xfer) begin
         r_rd_we   <= (b_num != 5'd0);
         r_rd_num  <= b_num;
         r_rd_data <= b_data;
      end else begin
         r_rd_we   <= 1'b0;
      end
   end

   // Scoreboard next state: a same-cycle set beats a B-return clear.
   always_comb begin
      w_set_mask = 32'd0;
      w_clr_mask = 32'd0;
      if (issue_valid && rst_b && (issue_num != 5'd0)) begin
         w_set_mask[issue_num] = 1'b1;
      end
      if (w_b_xfer) begin
         w_clr_mask[b_num] = 1'b1;
      end
      w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
      w_pending_nxt[0] = 1'b0;
      w_dup_issue      = |(w_set_mask & r_pending & ~w_clr_mask);
   end

   // Pending bits and the sticky double-issue flag.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_pending <= 32'd0;
         r_sb_err  <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_dup_issue) begin
            r_sb_err <= 1'b1;
         end
      end
   end

   // Operand busy: outstanding, or sitting in the output stage not yet committed.
   assign rs_busy = (rs_num != 5'd0) & (r_pending[rs_num] | (r_rd_we & (r_rd_num == rs_num)));
   assign rt_busy = (rt_num != 5'd0) & (r_pending[rt_num] | (r_rd_we & (r_rd_num == rt_num)));

   assign rd_we   = r_rd_we;
   assign rd_num  = r_rd_num;
   assign rd_data = r_rd_data;
   assign sb_err  = r_sb_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter with STARVE_LIMIT = 4. One table row is one clock
// cycle of stimulus with the hand-derived readies, busy flags and sb_err
// expected before the edge; each predicted transfer pushes the expected
// output-stage contents, popped and compared after the edge.
module tb_rf_wb_arbiter;

   typedef struct {
      bit          av;
      logic [4:0]  an;
      logic [31:0] ad;
      bit          bv;
      logic [4:0]  bn;
      logic [31:0] bd;
      bit          iv;
      logic [4:0]  inum;
      logic [4:0]  rs;
      logic [4:0]  rt;
      bit          ear;
      bit          ebr;
      bit          ers;
      bit          ert;
      bit          esb;
   } vec_t;

   logic        clk;
   logic        rst_b;
   logic        a_valid;
   logic [4:0]  a_num;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_num;
   logic [31:0] b_data;
   logic        b_ready;
   logic        issue_valid;
   logic [4:0]  issue_num;
   logic [4:0]  rs_num;
   logic [4:0]  rt_num;
   logic        rs_busy;
   logic        rt_busy;
   logic        rd_we;
   logic [4:0]  rd_num;
   logic [31:0] rd_data;
   logic        sb_err;

   logic [37:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   vec_t        tbl[$];

   rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_b(rst_b),
      .a_valid(a_valid), .a_num(a_num), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_num(b_num), .b_data(b_data), .b_ready(b_ready),
      .issue_valid(issue_valid), .issue_num(issue_num),
      .rs_num(rs_num), .rt_num(rt_num), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .rd_we(rd_we), .rd_num(rd_num), .rd_data(rd_data), .sb_err(sb_err)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit av, logic [4:0] an, logic [31:0] ad,
                               bit bv, logic [4:0] bn, logic [31:0] bd,
                               bit iv, logic [4:0] inum,
                               logic [4:0] rs, logic [4:0] rt,
                               bit ear, bit ebr, bit ers, bit ert, bit esb);
      vec_t v;
      v.av = av; v.an = an; v.ad = ad;
      v.bv = bv; v.bn = bn; v.bd = bd;
      v.iv = iv; v.inum = inum;
      v.rs = rs; v.rt = rt;
      v.ear = ear; v.ebr = ebr; v.ers = ers; v.ert = ert; v.esb = esb;
      return v;
   endfunction

   // Driver: one cycle of stimulus, pre-edge checks, scoreboard push/pop.
   task automatic step(input vec_t v, input int idx);
      logic [37:0] e;
      bit          pushed;
      string       t;
      t = $sformatf("row%0d", idx);
      @(negedge clk);
      a_valid = v.av; a_num = v.an; a_data = v.ad;
      b_valid = v.bv; b_num = v.bn; b_data = v.bd;
      issue_valid = v.iv; issue_num = v.inum;
      rs_num = v.rs; rt_num = v.rt;
      #1;
      chk({t, ".a_ready"}, 32'(a_ready), 32'(v.ear));
      chk({t, ".b_ready"}, 32'(b_ready), 32'(v.ebr));
      chk({t, ".rs_busy"}, 32'(rs_busy), 32'(v.ers));
      chk({t, ".rt_busy"}, 32'(rt_busy), 32'(v.ert));
      chk({t, ".sb_err"},  32'(sb_err),  32'(v.esb));
      pushed = 1'b0;
      if (v.av && v.ear) begin
         exp_q.push_back({(v.an != 5'd0), v.an, v.ad});
         pushed = 1'b1;
      end else if (v.bv && v.ebr) begin
         exp_q.push_back({(v.bn != 5'd0), v.bn, v.bd});
         pushed = 1'b1;
      end
      @(posedge clk);
      #1;
      if (pushed) begin
         e = exp_q.pop_front();
         chk({t, ".rd_we"},   32'(rd_we),  32'(e[37]));
         chk({t, ".rd_num"},  32'(rd_num), 32'(e[36:32]));
         chk({t, ".rd_data"}, rd_data,     e[31:0]);
      end else begin
         chk({t, ".rd_we_idle"}, 32'(rd_we), 32'd0);
      end
   endtask

   task automatic idle_inputs();
      a_valid = 0; a_num = 0; a_data = 0;
      b_valid = 0; b_num = 0; b_data = 0;
      issue_valid = 0; issue_num = 0;
      rs_num = 0; rt_num = 0;
   endtask

   initial begin
      vec_t v;
      idle_inputs();
      rst_b = 1'b0;

      //         av an  ad            bv bn  bd            iv in  rs  rt  ar br rs rt sb
      // A alone writes r5, then idle sees it in the output stage.
      tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          0, 0,  0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  5,  6, 1, 1, 1, 0, 0));
      // r0 write: handshake completes, no rd_we.
      tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 0,          0, 0,  0,  5, 1, 0, 0, 0, 0));
      // Issue r7, B returns r7.
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          1, 7,  7,  0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  7,  7, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,            1, 7, 32'h77,     0, 0,  7,  0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  7,  7, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  7,  7, 1, 1, 0, 0, 0));
      // Continuous A and B: A for 4 cycles, B on the 5th, then A resumes.
      tbl.push_back(mk(1, 1, 32'h11,       1, 10, 32'hB0B0,  0, 0,  0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 32'h22,       1, 10, 32'hB0B0,  0, 0,  1,  2, 1, 0, 1, 0, 0));
      tbl.push_back(mk(1, 3, 32'h3333,     1, 10, 32'hB0B0,  0, 0,  1,  2, 1, 0, 0, 1, 0));
      tbl.push_back(mk(1, 4, 32'h44,       1, 10, 32'hB0B0,  0, 0,  0,  0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5, 32'h55,       1, 10, 32'hB0B0,  0, 0,  0,  0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 5, 32'h55,       0, 0, 0,          0, 0, 10,  5, 1, 0, 1, 0, 0));
      // Issue r3, then issue r3 while B returns r3: set wins, no error.
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          1, 3,  5,  3, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,            1, 3, 32'h3,      1, 3,  3,  0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  3,  3, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  3,  0, 1, 1, 1, 0, 0));
      // Double issue of r9 sets the sticky error.
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          1, 9,  9,  0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          1, 9,  9,  0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  9,  0, 1, 1, 1, 0, 1));
      // A and B together with no starvation: A wins.
      tbl.push_back(mk(1, 8, 32'h88,       1, 9, 32'h99,     0, 0,  9,  0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  9,  8, 1, 1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0,            1, 9, 32'h99,     0, 0,  9,  0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  9,  0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0,          0, 0,  9,  0, 1, 1, 0, 0, 1));

      // Reset state while held low.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.rd_we",   32'(rd_we),   32'd0);
      chk("rst.rd_num",  32'(rd_num),  32'd0);
      chk("rst.rd_data", rd_data,      32'd0);
      chk("rst.sb_err",  32'(sb_err),  32'd0);
      chk("rst.a_ready", 32'(a_ready), 32'd0);
      chk("rst.b_ready", 32'(b_ready), 32'd0);
      @(negedge clk);
      rst_b = 1'b1;

      foreach (tbl[i]) step(tbl[i], i);

      // Back-to-back A traffic at one write per cycle, random destinations.
      for (int k = 0; k < 16; k++) begin
         v = mk(1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0, 0, 0,
                0, 0, 1, 0, 0, 0, 1);
         step(v, 100 + k);
      end

      // Reset mid-operation: r4 pending and B r12 in the output stage.
      step(mk(0, 0, 0, 1, 12, 32'hC0C0, 1, 4, 4, 12, 1, 1, 0, 0, 1), 200);
      @(negedge clk);
      rst_b = 1'b0;
      a_valid = 1; a_num = 6; a_data = 32'h6;
      b_valid = 1; b_num = 12; b_data = 32'hC0C1;
      issue_valid = 1; issue_num = 4;
      rs_num = 4; rt_num = 12;
      #1;
      chk("rstmid.a_ready",  32'(a_ready), 32'd0);
      chk("rstmid.b_ready",  32'(b_ready), 32'd0);
      chk("rstmid.rs_pre",   32'(rs_busy), 32'd1);
      chk("rstmid.rt_pre",   32'(rt_busy), 32'd1);
      @(posedge clk);
      #1;
      chk("rstmid.rd_we",    32'(rd_we),   32'd0);
      chk("rstmid.rd_num",   32'(rd_num),  32'd0);
      chk("rstmid.rd_data",  rd_data,      32'd0);
      chk("rstmid.sb_err",   32'(sb_err),  32'd0);
      chk("rstmid.rs_busy",  32'(rs_busy), 32'd0);
      chk("rstmid.rt_busy",  32'(rt_busy), 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      idle_inputs();

      // Normal operation resumes after reset.
      step(mk(1, 6, 32'h600D, 0, 0, 0, 0, 0, 4, 12, 1, 0, 0, 0, 0), 300);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 1, 1, 0, 0), 301);

      chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
